// File: rtl/apb_slave_ctrl.sv
// apb_slave_ctrl: APB slave front-end for the timer register block.
// Generates the transfer handshake with WAIT_CYCLES wait states, single-cycle
// register write/read strobes, checks writes to the control register and keeps
// a saturating count of error responses.
// Optional feature: define ADDR_CHECK_EN to reject unmapped (addr > MAX_ADDR)
// or misaligned accesses with pslverr. Without it every address is accepted.
module apb_slave_ctrl #(
    parameter int                ADDR_W      = 12,
    parameter int                DATA_W      = 32,
    parameter int                WAIT_CYCLES = 1,
    parameter logic [ADDR_W-1:0] CTRL_ADDR   = 12'h000,
    parameter int                DIV_MAX     = 8,
    parameter int                ERR_CNT_W   = 8,
    parameter logic [ADDR_W-1:0] MAX_ADDR    = 12'h03C
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   psel,
    input  logic                   penable,
    input  logic                   pwrite,
    input  logic [ADDR_W-1:0]      addr,
    input  logic [DATA_W-1:0]      wdata,
    input  logic [DATA_W/8-1:0]    pstrb,
    input  logic                   timer_en,
    input  logic                   div_en,
    input  logic [3:0]             div_val,
    input  logic                   err_clr,
    output logic                   pready,
    output logic                   pslverr,
    output logic                   wr_en,
    output logic                   rd_en,
    output logic [ERR_CNT_W-1:0]   err_cnt
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_t;

    // Wait counter is 4 bits wide, so WAIT_CYCLES is meaningful in 1..15.
    localparam logic [3:0] WAIT_L = 4'(WAIT_CYCLES);
    // Divider field is 4 bits; a limit of 15 or more can never be exceeded.
    localparam logic [3:0] DIV_MAX_L = (DIV_MAX > 15) ? 4'd15 : 4'(DIV_MAX);
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [3:0]             r_cnt;
    logic [3:0]             w_cnt_nxt;
    logic [ERR_CNT_W-1:0]   r_err_cnt;

    logic                   w_acc;
    logic                   w_ctrl_wr;
    logic [3:0]             w_div_wr;
    logic                   w_err_lock;
    logic                   w_err_range;
    logic                   w_err_addr;
    logic                   w_unused;

    assign w_acc = psel & penable;

    // State register and wait counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values regardless of statement order.
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state and wait-counter update for the transfer handshake
    always_comb begin
        // NOTE: defaults first, so no path leaves a target unassigned and no
        // latch is inferred.
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_acc) begin
                    w_state_nxt = ST_ACC;
                    w_cnt_nxt   = 4'd1;
                end
            end
            ST_ACC: begin
                // Abort (acc dropped) and completion both return to IDLE.
                if (!w_acc || (r_cnt == WAIT_L)) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + 4'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Completion is decoded from the registered state; it drops with acc.
    assign pready = (r_state == ST_ACC) & (r_cnt == WAIT_L) & w_acc;

    // Control-register write checks use the values present in the pready
    // cycle; nothing from earlier wait states is captured.
    assign w_ctrl_wr   = pready & pwrite & (addr == CTRL_ADDR);
    assign w_div_wr    = wdata[11:8];
    assign w_err_lock  = w_ctrl_wr & timer_en &
                         ((pstrb[1] & (w_div_wr != div_val)) |
                          (pstrb[0] & (wdata[1] != div_en)));
    assign w_err_range = w_ctrl_wr & pstrb[1] & (w_div_wr > DIV_MAX_L);

`ifdef ADDR_CHECK_EN
    assign w_err_addr = (addr > MAX_ADDR) | (addr[1:0] != 2'b00);
    // Sink for data/strobe bits that no check looks at.
    assign w_unused   = ^{wdata, pstrb};
`else
    assign w_err_addr = 1'b0;
    // Sink for data/strobe bits that no check looks at; MAX_ADDR only
    // matters when address checking is compiled in.
    assign w_unused   = ^{wdata, pstrb, MAX_ADDR};
`endif

    assign pslverr = pready & (w_err_lock | w_err_range | w_err_addr);
    assign wr_en   = pready &  pwrite & ~pslverr;
    assign rd_en   = pready & ~pwrite & ~pslverr;

    // Saturating error-response counter; clear wins over a same-cycle error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (err_clr) begin
            r_err_cnt <= '0;
        end else if (pslverr && (r_err_cnt != ERR_CNT_MAX)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_apb_slave_ctrl.sv
// tb_apb_slave_ctrl: scoreboard bench for apb_slave_ctrl. A driver issues APB
// transfers and pushes the expected response from a behavioural model; a
// monitor pops and compares whenever the DUT presents pready.
module tb_apb_slave_ctrl;

    localparam int          ADDR_W  = 12;
    localparam int          DATA_W  = 32;
    localparam int          TB_WAIT = 3;
    localparam int          DIV_MAX = 8;
    localparam int          ERR_W   = 8;
    localparam int          ERR_MAX = (1 << ERR_W) - 1;
    localparam logic [11:0] CTRL_A  = 12'h000;
    localparam logic [11:0] MAX_A   = 12'h03C;
    localparam int          BUDGET  = 40;

    logic               clk;
    logic               rst_n;
    logic               psel;
    logic               penable;
    logic               pwrite;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  wdata;
    logic [3:0]         pstrb;
    logic               timer_en;
    logic               div_en;
    logic [3:0]         div_val;
    logic               err_clr;
    logic               pready;
    logic               pslverr;
    logic               wr_en;
    logic               rd_en;
    logic [ERR_W-1:0]   err_cnt;

    apb_slave_ctrl #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .WAIT_CYCLES (TB_WAIT),
        .CTRL_ADDR   (CTRL_A),
        .DIV_MAX     (DIV_MAX),
        .ERR_CNT_W   (ERR_W),
        .MAX_ADDR    (MAX_A)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .addr     (addr),
        .wdata    (wdata),
        .pstrb    (pstrb),
        .timer_en (timer_en),
        .div_en   (div_en),
        .div_val  (div_val),
        .err_clr  (err_clr),
        .pready   (pready),
        .pslverr  (pslverr),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .err_cnt  (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit slverr;
        bit wr;
        bit rd;
        int err_before;
        int err_after;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks;
    int   n_errors;
    int   model_cnt;
    int   mon_run;
    bit   mon_pend;
    int   mon_pend_val;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference rules: a completed transfer errors if it is a control write
    // that changes a locked field or sets an out-of-range divider, or (with
    // address checking) if the address is unmapped or misaligned.
    function automatic bit model_err(input logic [11:0] a, input logic [31:0] wd,
                                     input logic [3:0] st, input bit wr,
                                     input bit ten, input bit den, input int dval);
        longint w     = longint'(wd);
        int     s     = int'(st);
        int     div_w = int'((w / 256) % 16);
        int     bit1  = int'((w / 2) % 2);
        bit     ctrl  = wr && (a == CTRL_A);
        bit     lock  = ten && (((s / 2) % 2 == 1 && div_w != dval) ||
                                (s % 2 == 1 && bit1 != int'(den)));
        bit     rng   = ((s / 2) % 2 == 1) && (div_w > DIV_MAX);
        bit     aerr;
`ifdef ADDR_CHECK_EN
        aerr = (a > MAX_A) || (int'(a) % 4 != 0);
`else
        aerr = 1'b0;
`endif
        return (ctrl && (lock || rng)) || aerr;
    endfunction

    task automatic drive_bus(input logic [11:0] a, input logic [31:0] wd,
                             input logic [3:0] st, input bit wr);
        addr   = a;
        wdata  = wd;
        pstrb  = st;
        pwrite = wr;
    endtask

    task automatic drive_garbage();
        drive_bus(12'($urandom), $urandom, 4'($urandom), 1'($urandom));
    endtask

    // One complete APB transfer starting with its setup phase. Called at
    // posedge+1; returns at posedge+1 of the cycle after pready.
    task automatic do_xfer(input logic [11:0] a, input logic [31:0] wd,
                           input logic [3:0] st, input bit wr,
                           input bit clr, input bit scramble);
        exp_t e;
        bit   err;
        bit   done;
        int   k;
        err          = model_err(a, wd, st, wr, timer_en, div_en, int'(div_val));
        e.slverr     = err;
        e.wr         = wr && !err;
        e.rd         = !wr && !err;
        e.err_before = clr ? 0 : model_cnt;
        if (clr)
            e.err_after = 0;
        else if (err)
            e.err_after = (model_cnt + 1 > ERR_MAX) ? ERR_MAX : model_cnt + 1;
        else
            e.err_after = model_cnt;
        model_cnt = e.err_after;
        sb_q.push_back(e);

        err_clr = clr;
        psel    = 1'b1;
        penable = 1'b0;
        if (scramble) drive_garbage();
        else          drive_bus(a, wd, st, wr);
        @(posedge clk); #1;
        penable = 1'b1;
        k    = 1;
        done = 1'b0;
        while (!done) begin
            if (!scramble || k == TB_WAIT + 1) drive_bus(a, wd, st, wr);
            else                               drive_garbage();
            @(negedge clk);
            if (pready === 1'b1) begin
                done = 1'b1;
            end else if (k >= BUDGET) begin
                check("xfer_timeout_pready", pready, 1);
                done = 1'b1;
            end
            @(posedge clk); #1;
            k++;
        end
        psel    = 1'b0;
        penable = 1'b0;
        err_clr = 1'b0;
    endtask

    // Transfer abandoned after n_pen access cycles; never completes.
    task automatic do_abort(input int n_pen);
        psel    = 1'b1;
        penable = 1'b0;
        drive_bus(12'h004, $urandom, 4'hF, 1'b1);
        for (int i = 0; i < n_pen; i++) begin
            @(posedge clk); #1;
            penable = 1'b1;
            @(negedge clk);
            check("abort_no_pready", {pready, wr_en}, 2'b00);
        end
        @(posedge clk); #1;
        psel    = 1'b0;
        penable = 1'b0;
        @(negedge clk);
        check("abort_dropped_no_pready", {pready, wr_en, rd_en}, 3'b000);
        @(posedge clk); #1;
    endtask

    // Monitor: compares DUT responses against the scoreboard queue.
    initial begin
        mon_run  = 0;
        mon_pend = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_run  = 0;
                mon_pend = 1'b0;
            end else begin
                if (mon_pend) begin
                    check("err_cnt_after", err_cnt, mon_pend_val);
                    mon_pend = 1'b0;
                end
                if (psel && penable) mon_run++;
                else                 mon_run = 0;
                if (pready) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_pready", pready, 0);
                    end else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        check("pslverr", pslverr, e.slverr);
                        check("wr_en", wr_en, e.wr);
                        check("rd_en", rd_en, e.rd);
                        check("err_cnt_at_pready", err_cnt, e.err_before);
                        check("access_cycles", mon_run, TB_WAIT + 1);
                        mon_pend     = 1'b1;
                        mon_pend_val = e.err_after;
                    end
                end else begin
                    check("idle_outputs", {pslverr, wr_en, rd_en}, 3'b000);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        model_cnt = 0;
        rst_n     = 1'b0;
        psel      = 1'b0;
        penable   = 1'b0;
        err_clr   = 1'b0;
        timer_en  = 1'b0;
        div_en    = 1'b0;
        div_val   = 4'd0;
        drive_bus(12'h000, 32'h0, 4'h0, 1'b0);

        #3;
        check("reset_pready", pready, 0);
        check("reset_pslverr", pslverr, 0);
        check("reset_strobes", {wr_en, rd_en}, 2'b00);
        check("reset_err_cnt", err_cnt, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Plain write and read, then a back-to-back write.
        do_xfer(12'h004, 32'h12345678, 4'hF, 1'b1, 1'b0, 1'b0);
        do_xfer(12'h008, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        do_xfer(12'h010, 32'hCAFE0001, 4'hF, 1'b1, 1'b0, 1'b0);

        // Locked divider change, then a write not touching the locked fields.
        timer_en = 1'b1;
        div_en   = 1'b0;
        div_val  = 4'd2;
        do_xfer(CTRL_A, 32'h00000300, 4'h2, 1'b1, 1'b0, 1'b0);
        do_xfer(CTRL_A, 32'h00000300, 4'h4, 1'b1, 1'b0, 1'b0);

        // Out-of-range divider with the timer stopped; boundary value passes.
        timer_en = 1'b0;
        do_xfer(CTRL_A, 32'h00000900, 4'h2, 1'b1, 1'b0, 1'b0);
        do_xfer(CTRL_A, 32'h00000800, 4'h2, 1'b1, 1'b0, 1'b0);

        // Unmapped read and misaligned write.
        do_xfer(12'h040, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        do_xfer(12'h006, 32'h55AA55AA, 4'hF, 1'b1, 1'b0, 1'b0);

        // Aborts, then a normal transfer must still see the full latency.
        do_abort(1);
        do_abort(TB_WAIT);
        do_xfer(12'h00C, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);

        // Randomized traffic with wait-state scrambling of addr/data/pwrite.
        for (int n = 0; n < 200; n++) begin
            logic [11:0] a;
            logic [31:0] wd;
            timer_en = 1'($urandom);
            div_en   = 1'($urandom);
            div_val  = 4'($urandom_range(0, 12));
            case ($urandom_range(0, 3))
                0, 1:    a = CTRL_A;
                2:       a = 12'($urandom_range(0, 17) * 4);
                default: a = 12'($urandom);
            endcase
            wd = $urandom;
            if ($urandom_range(0, 1) == 1) wd[11:8] = div_val;
            if ($urandom_range(0, 1) == 1) wd[1]    = div_en;
            do_xfer(a, wd, 4'($urandom), 1'($urandom), 1'b0, 1'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end

        // Reset asserted mid-access: outputs drop at once, no pready.
        timer_en = 1'b0;
        do_xfer(CTRL_A, 32'h00000900, 4'h2, 1'b1, 1'b0, 1'b0);
        psel    = 1'b1;
        penable = 1'b0;
        drive_bus(12'h004, 32'h1, 4'hF, 1'b1);
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_pready", pready, 0);
        check("rst_mid_strobes", {pslverr, wr_en, rd_en}, 3'b000);
        check("rst_mid_err_cnt", err_cnt, 0);
        @(negedge clk);
        check("rst_hold_pready", pready, 0);
        @(posedge clk); #1;
        psel      = 1'b0;
        penable   = 1'b0;
        rst_n     = 1'b1;
        model_cnt = 0;
        @(posedge clk); #1;
        do_xfer(12'h008, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);

        // Saturation: more error responses than the counter can hold.
        timer_en = 1'b0;
        for (int n = 0; n < ERR_MAX + 4; n++)
            do_xfer(CTRL_A, 32'h00000900, 4'h2, 1'b1, 1'b0, 1'b0);
        // Clear asserted together with an error response: clear wins.
        do_xfer(CTRL_A, 32'h00000900, 4'h2, 1'b1, 1'b1, 1'b0);
        // Standalone clear after a fresh error.
        do_xfer(CTRL_A, 32'h00000900, 4'h2, 1'b1, 1'b0, 1'b0);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr   = 1'b0;
        model_cnt = 0;
        check("err_clr_standalone", err_cnt, model_cnt);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/apb_slave_ctrl.md
Name: apb_slave_ctrl

Overview:
Parametrised APB slave front-end for the timer register block. It generates the transfer handshake with a configurable number of wait states, and produces single-cycle register write/read strobes. It checks writes to the control register, flags illegal writes with pslverr, and keeps a saturating count of error responses. It sits between the APB bus and the timer register file.

Parameters:
ADDR_W, 12, width of addr
DATA_W, 32, width of wdata; must be >= 16 and a multiple of 8
WAIT_CYCLES, 1, wait states inserted before pready; legal range 1..15
CTRL_ADDR, 12'h000, address of the control register (holds div_en and div_val)
DIV_MAX, 8, largest legal divider value written to wdata[11:8]
ERR_CNT_W, 8, width of the error counter
MAX_ADDR, 12'h03C, highest mapped address; used only with the optional feature

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
psel  input  1  APB select
penable  input  1  APB enable
pwrite  input  1  1 = write, 0 = read
addr  input  ADDR_W  APB address
wdata  input  DATA_W  APB write data
pstrb  input  DATA_W/8  APB byte strobes
timer_en  input  1  current timer enable (control register)
div_en  input  1  current divider enable (control register)
div_val  input  4  current divider value (control register)
err_clr  input  1  synchronous clear of err_cnt
pready  output  1  transfer complete
pslverr  output  1  error response, valid only while pready=1
wr_en  output  1  register write strobe
rd_en  output  1  register read strobe
err_cnt  output  ERR_CNT_W  saturating count of pslverr responses

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, wait counter=0, err_cnt=0. pready, pslverr, wr_en and rd_en are all 0.
- Access condition acc = psel & penable.
- FSM states IDLE and ACC, with a wait counter cnt of width 4.
  - IDLE: when acc=1, go to ACC with cnt<=1. Otherwise stay in IDLE.
  - ACC: when acc=0, the transfer is aborted. Go to IDLE; no strobe and no error count.
  - ACC: when acc=1 and cnt==WAIT_CYCLES, the transfer completes this cycle. Go to IDLE.
  - ACC: otherwise cnt<=cnt+1.
- pready = (state==ACC) & (cnt==WAIT_CYCLES) & acc. This is combinational from the registered state.
- The access phase lasts WAIT_CYCLES+1 cycles. For WAIT_CYCLES=1, pready is high in the 2nd penable cycle.
- Each pready pulse lasts exactly 1 cycle, because the FSM returns to IDLE.
- Back-to-back transfers: the next setup phase (psel=1, penable=0) is seen in IDLE. No extra idle cycle is needed.
- Error terms are evaluated only when pready=1, pwrite=1 and addr==CTRL_ADDR:
  - err_lock = timer_en & ((pstrb[1] & wdata[11:8]!=div_val) | (pstrb[0] & wdata[1]!=div_en)).
  - err_range = pstrb[1] & (wdata[11:8] > DIV_MAX).
- pslverr = pready & (err_lock | err_range | err_addr). err_addr is 0 unless the optional feature is compiled in.
- wr_en = pready & pwrite & ~pslverr. A write that receives an error response does not update any register.
- rd_en = pready & ~pwrite & ~pslverr.
- err_cnt:
  - Increments on each cycle with pslverr=1 and saturates at all-ones.
  - err_clr=1 sets it to 0; err_clr has priority over a simultaneous increment.
- A reset asserted mid-transfer forces IDLE immediately. No pready is produced for that transfer.
- Signal changes during a wait state (addr, wdata, pwrite) are not latched. The values present in the pready cycle are the ones used.

Optional Feature:
Macro ADDR_CHECK_EN.
- Defined: err_addr = (addr > MAX_ADDR) | (addr[1:0] != 0). This applies to both reads and writes. Unmapped or misaligned accesses complete with pslverr=1, no wr_en or rd_en, and an err_cnt increment.
- Not defined: err_addr is tied to 0 and MAX_ADDR is unused. All addresses are accepted.

Test Plan:
- WAIT_CYCLES=1, write addr=0x004, wdata=0x12345678, pstrb=0xF, penable held -> pready=1 and wr_en=1 in the 2nd penable cycle only, pslverr=0, err_cnt=0.
- WAIT_CYCLES=3, read addr=0x008 -> pready=1 and rd_en=1 in the 4th penable cycle. Then a back-to-back write follows immediately -> pready again after 4 penable cycles.
- timer_en=1, div_val=2, write addr=0x000, wdata=0x00000300, pstrb=0x2 -> pready=1, pslverr=1, wr_en=0, err_cnt 0->1. Repeat with pstrb=0x4 -> pslverr=0, wr_en=1.
- timer_en=0, write addr=0x000, wdata=0x00000900, pstrb=0x2 -> pslverr=1 (9>8). Drive err_cnt to 255 -> stays 255. err_clr asserted with a simultaneous error -> err_cnt=0.
- psel dropped after 1 penable cycle with WAIT_CYCLES=2 -> no pready, no wr_en, FSM back in IDLE. rst_n pulsed mid-ACC -> all outputs 0 asynchronously.
- ADDR_CHECK_EN defined: read addr=0x040 and write addr=0x006 -> pslverr=1, rd_en=0 and wr_en=0, err_cnt +2. Macro undefined: same accesses -> pslverr=0 and strobes asserted.
